// File: rtl/multi_counter.sv
// Bank of NUM_CH independent up/down event counters with per-channel load,
// wrap-or-saturate overflow handling and sticky overflow flags.

module multi_counter_ch #(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hit,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             ovf,
    output logic             ovf_next
);
    localparam logic [WIDTH-1:0] MAX = '1;

    logic [WIDTH-1:0] count_next;

    // A same-cycle overflow overrides clr_flags because the set is applied last.
    always_comb begin
        count_next = count;
        ovf_next   = ovf & ~clr_flags;
        if (hit) begin
            if (load) begin
                count_next = load_val;
            end else if (en) begin
                if (!dir) begin
                    if (count == MAX) begin
                        ovf_next   = 1'b1;
                        count_next = (SATURATE != 0) ? MAX : '0;
                    end else begin
                        count_next = count + 1'b1;
                    end
                end else begin
                    if (count == '0) begin
                        ovf_next   = 1'b1;
                        count_next = (SATURATE != 0) ? '0 : MAX;
                    end else begin
                        count_next = count - 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            count <= count_next;
            ovf   <= ovf_next;
        end
    end
endmodule

module multi_counter #(
    parameter  int NUM_CH   = 4,
    parameter  int WIDTH    = 8,
    parameter  int SATURATE = 0,
    localparam int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    dir,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    load,
    input  logic [WIDTH-1:0]        load_val,
    input  logic                    clr_flags,
    output logic [NUM_CH*WIDTH-1:0] count,
    output logic [NUM_CH-1:0]       ovf,
    output logic                    any_ovf
);
    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] ovf_next;

    // Out-of-range indexes (non-power-of-2 NUM_CH) select no channel at all.
    always_comb begin
        hit = '0;
        if (int'(sel) < NUM_CH) hit[sel] = 1'b1;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        multi_counter_ch #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .hit       (hit[i]),
            .en        (en),
            .dir       (dir),
            .load      (load),
            .load_val  (load_val),
            .clr_flags (clr_flags),
            .count     (count[i*WIDTH +: WIDTH]),
            .ovf       (ovf[i]),
            .ovf_next  (ovf_next[i])
        );
    end

    // Built from next-state flags so any_ovf lands on the same edge as ovf.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) any_ovf <= 1'b0;
        else       any_ovf <= |ovf_next;
    end
endmodule

// File: tb/tb_multi_counter.sv
// Scoreboard bench for multi_counter: a wrapping 4-channel bank and a saturating
// 3-channel bank share one stimulus stream against an arithmetic reference model.

module tb_multi_counter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0, dir = 1'b0, load = 1'b0, clr_flags = 1'b0;
    logic [1:0]  sel = '0;
    logic [7:0]  load_val = '0;

    logic [31:0] cw;
    logic [3:0]  ow;
    logic        aw;
    logic [23:0] cs;
    logic [2:0]  os;
    logic        as_s;

    always #5 clk = ~clk;

    multi_counter #(.NUM_CH(4), .WIDTH(8), .SATURATE(0)) dut_w (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .sel(sel), .load(load),
        .load_val(load_val), .clr_flags(clr_flags), .count(cw), .ovf(ow), .any_ovf(aw)
    );

    multi_counter #(.NUM_CH(3), .WIDTH(8), .SATURATE(1)) dut_s (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .sel(sel), .load(load),
        .load_val(load_val), .clr_flags(clr_flags), .count(cs), .ovf(os), .any_ovf(as_s)
    );

    typedef struct packed {
        logic [31:0] cw;
        logic [3:0]  ow;
        logic        aw;
        logic [23:0] cs;
        logic [2:0]  os;
        logic        as_s;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cnt[2][4];
    bit   ov[2][4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++) begin
                cnt[d][i] = 0;
                ov[d][i]  = 1'b0;
            end
    endfunction

    // d=0: 4 channels wrapping; d=1: 3 channels saturating.
    function automatic void model_step(int d, bit e, bit dr, int s, bit l, int lv, bit c);
        int n = (d == 0) ? 4 : 3;
        int v;
        if (c) for (int i = 0; i < 4; i++) ov[d][i] = 1'b0;
        if (s >= n) return;
        if (l) begin
            cnt[d][s] = lv;
        end else if (e) begin
            v = cnt[d][s] + (dr ? -1 : 1);
            if (v < 0 || v > 255) begin
                ov[d][s] = 1'b1;
                if (d == 1) v = (v < 0) ? 0 : 255;
                else        v = (v + 256) % 256;
            end
            cnt[d][s] = v;
        end
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        e = '0;
        for (int i = 0; i < 4; i++) begin
            e.cw[i*8 +: 8] = 8'(cnt[0][i]);
            e.ow[i]        = ov[0][i];
        end
        for (int i = 0; i < 3; i++) begin
            e.cs[i*8 +: 8] = 8'(cnt[1][i]);
            e.os[i]        = ov[1][i];
        end
        e.aw   = |e.ow;
        e.as_s = |e.os;
        return e;
    endfunction

    task automatic step(input bit r, input bit e, input bit d, input logic [1:0] s,
                        input bit l, input logic [7:0] lv, input bit c);
        @(negedge clk);
        reset = r; en = e; dir = d; sel = s; load = l; load_val = lv; clr_flags = c;
        if (r) begin
            model_reset();
            #1;
            chk("async_rst_cw", 32'(cw), 32'h0);
            chk("async_rst_ow", 32'(ow), 32'h0);
            chk("async_rst_aw", 32'(aw), 32'h0);
            chk("async_rst_cs", 32'(cs), 32'h0);
            chk("async_rst_os", 32'(os), 32'h0);
            chk("async_rst_as", 32'(as_s), 32'h0);
        end else begin
            model_step(0, e, d, int'(s), l, int'(lv), c);
            model_step(1, e, d, int'(s), l, int'(lv), c);
        end
        q.push_back(snapshot());
    endtask

    task automatic post();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every edge is an output beat; pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("wrap_count", 32'(cw), 32'(e.cw));
                chk("wrap_ovf",   32'(ow), 32'(e.ow));
                chk("wrap_any",   32'(aw), 32'(e.aw));
                chk("sat_count",  32'(cs), 32'(e.cs));
                chk("sat_ovf",    32'(os), 32'(e.os));
                chk("sat_any",    32'(as_s), 32'(e.as_s));
            end
        end
    end

    initial begin
        model_reset();
        step(1, 0, 0, 0, 0, 8'h00, 0);
        step(0, 0, 0, 0, 1, 8'h37, 0);
        step(0, 0, 0, 1, 0, 8'h00, 0);
        step(1, 1, 0, 0, 1, 8'h55, 0);   // mid-operation reset with count[0]=0x37
        repeat (5) step(0, 0, 0, 0, 0, 8'h00, 0);

        // Steering
        repeat (3) step(0, 1, 0, 2, 0, 8'h00, 0);
        step(0, 1, 0, 0, 0, 8'h00, 0);
        repeat (2) step(0, 1, 0, 3, 0, 8'h00, 0);
        post();
        chk("steer_cw", 32'(cw), 32'h02030001);
        chk("steer_cs", 32'(cs), 32'h00030001);
        chk("steer_ow", 32'(ow), 32'h0);

        // Wrap on ch1
        step(0, 0, 0, 1, 1, 8'hFE, 0);
        step(0, 1, 0, 1, 0, 8'h00, 0);
        post();
        chk("wrap_ff", 32'(cw[15:8]), 32'hFF);
        step(0, 1, 0, 1, 0, 8'h00, 0);
        post();
        chk("wrap_00", 32'(cw[15:8]), 32'h00);
        chk("wrap_ovf1", 32'(ow[1]), 32'h1);
        step(0, 1, 0, 1, 0, 8'h00, 0);
        post();
        chk("wrap_01", 32'(cw[15:8]), 32'h01);
        chk("wrap_sticky", 32'(ow[1]), 32'h1);
        chk("wrap_any1", 32'(aw), 32'h1);

        // Saturate on ch0
        step(0, 0, 0, 0, 1, 8'h01, 1);
        step(0, 1, 1, 0, 0, 8'h00, 0);
        post();
        chk("sat_dec1", 32'(cs[7:0]), 32'h00);
        chk("sat_noovf", 32'(os[0]), 32'h0);
        step(0, 1, 1, 0, 0, 8'h00, 0);
        post();
        chk("sat_dec2", 32'(cs[7:0]), 32'h00);
        chk("sat_ovf0", 32'(os[0]), 32'h1);
        step(0, 1, 1, 0, 0, 8'h00, 0);

        // Load beats en, then clear-vs-set collision
        step(0, 0, 0, 2, 1, 8'hFF, 1);
        step(0, 1, 0, 2, 1, 8'h80, 0);
        post();
        chk("prio_cnt2", 32'(cw[23:16]), 32'h80);
        chk("prio_ovf2", 32'(ow[2]), 32'h0);
        step(0, 0, 0, 3, 1, 8'hFF, 0);
        step(0, 1, 0, 3, 0, 8'h00, 0);
        step(0, 0, 0, 1, 1, 8'hFF, 0);
        step(0, 1, 0, 1, 0, 8'h00, 1);
        post();
        chk("clr_collide", 32'(ow), 32'h2);

        // Out-of-range on the 3-channel bank
        repeat (2) step(0, 1, 0, 3, 0, 8'h00, 0);
        repeat (2) step(0, 0, 0, 3, 1, 8'hAA, 0);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            bit          r, e, d, l, c;
            logic [7:0]  lv;
            r = ($urandom_range(0, 63) == 0);
            e = $urandom_range(0, 1);
            d = $urandom_range(0, 1);
            l = ($urandom_range(0, 9) == 0);
            c = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0: lv = 8'hFF;
                1: lv = 8'h00;
                2: lv = 8'(($urandom_range(0, 1) != 0) ? 8'hFE : 8'h01);
                default: lv = 8'($urandom);
            endcase
            step(r, e, d, 2'($urandom_range(0, 3)), l, lv, c);
        end

        step(0, 0, 0, 0, 0, 8'h00, 0);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multi_counter.md
Name: multi_counter

Overview:
- Parametrised bank of NUM_CH independent up/down event counters.
- A binary channel index steers each event to exactly one channel.
- Adds parallel load, wrap or saturate overflow handling, and sticky per-channel overflow flags.
- Used as the standard event/statistics counter bank inside fuzzing targets; all counts are exposed as one flat registered output bus.

Parameters:
NUM_CH, 4, number of counter channels (2..256)
WIDTH, 8, bits per counter (2..32)
SATURATE, 0, 0 = counters wrap modulo 2^WIDTH; 1 = counters clamp at 0 / 2^WIDTH-1
SEL_W, $clog2(NUM_CH) (localparam, minimum 1), width of the channel index

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
en  input  1  count event strobe for channel sel
dir  input  1  0 = increment, 1 = decrement; sampled with en
sel  input  SEL_W  target channel index for en and load
load  input  1  write load_val into channel sel
load_val  input  WIDTH  value for load
clr_flags  input  1  clear all sticky overflow flags
count  output  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]; registered
ovf  output  NUM_CH  sticky per-channel overflow flag; registered
any_ovf  output  1  OR of all ovf bits; registered, same cycle as ovf

Behaviour:
- Reset (asynchronous, active-high): all counts = 0, ovf = 0, any_ovf = 0 immediately. Reset has priority over every other input.
- Clocked updates take effect on the rising clk edge. Results are visible on count/ovf one cycle after the inputs are sampled. No combinational input-to-output paths.
- Channel selection: only channel sel may change on a given edge. All other channels hold their value.
- If sel >= NUM_CH (non-power-of-2 NUM_CH), en and load are ignored and nothing changes.
- Priority on the selected channel: load > en. If load=1, count[sel] <= load_val, en/dir are ignored that cycle, and ovf is unaffected.
- Increment (en=1, dir=0):
  - Value below max (2^WIDTH-1): count + 1.
  - At max, SATURATE=0: wraps to 0 and sets ovf[sel].
  - At max, SATURATE=1: holds at max and sets ovf[sel].
- Decrement (en=1, dir=1):
  - Value above 0: count - 1.
  - At 0, SATURATE=0: wraps to max and sets ovf[sel].
  - At 0, SATURATE=1: holds at 0 and sets ovf[sel].
- Arithmetic is unsigned, WIDTH bits, with no carry into adjacent channel fields.
- ovf is sticky until clr_flags=1 or reset.
- clr_flags with a same-cycle overflow event: the set wins for that channel; all other channels clear.
- any_ovf is registered from the next-state ovf vector, so it is always consistent with ovf in the same cycle.
- Reset asserted mid-operation discards any in-flight load/en. After deassertion, the first sampled edge behaves exactly as after power-up.
- Degenerate NUM_CH=2, SATURATE=0, with dir=0 and en=1 every cycle: sel acts as the old two-channel select. Channel 1 counts when sel=1, channel 0 when sel=0.

Test Plan:
- Reset/hold: assert reset mid-count with count[0]=0x37 -> all counts 0x00 and ovf=0 before the next clk edge. Deassert with en=0 for 5 cycles -> all stay 0.
- Steering (NUM_CH=4, WIDTH=8): 3 en pulses on sel=2, 1 on sel=0, 2 on sel=3 -> count = {0x02,0x03,0x00,0x01} (ch3..ch0). ovf=0.
- Wrap (SATURATE=0): load 0xFE into ch1, then 3 increments -> 0xFF, 0x00, 0x01. ovf[1] rises on the 0xFF->0x00 edge and stays set. any_ovf=1.
- Saturate (SATURATE=1): load 0x01 into ch0, then 3 decrements -> 0x00, 0x00, 0x00. ovf[0] set on the second decrement.
- Priority/collision: load=1, en=1, load_val=0x80 on ch2 at count 0xFF -> count[2]=0x80, ovf[2] stays 0. Then clr_flags=1 together with an overflow on ch1 while ovf[3]=1 -> ovf[3] clears, ovf[1]=1.
- Out-of-range (NUM_CH=3): en and load with sel=3 for 4 cycles -> no count or ovf change on any channel.
